// File: rtl/kbd_pkg.sv
// kbd_pkg: shared FSM states, key codes and limits for the keypad entry block.
package kbd_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, ACT, WAIT_RELEASE} state_t;
    localparam logic [4:0] K_DF    = 5'h0F;
    localparam logic [4:0] K_ENTER = 5'h10;
    localparam logic [4:0] K_BKSP  = 5'h11;
    localparam logic [4:0] K_CLR   = 5'h12;
    localparam logic [4:0] K_NOP   = 5'h13;
    localparam int MAX_DIGITS = 8;
    function automatic logic [2:0] lowest_low(input logic [4:0] col);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (!col[i]) idx = 3'(i);
        return idx;
    endfunction
    // Column 4 holds the function keys, one per row, in code order.
    function automatic logic [4:0] key_code(input logic [1:0] row, input logic [2:0] c);
        return c[2] ? K_ENTER + {3'b000, row} : {1'b0, row, c[1:0]};
    endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix pins and entered-value outputs.
interface keypad_entry_if;
    logic [3:0]  key_row;
    logic [4:0]  key_col;
    logic [31:0] keyboard_in;
    logic        keyboard_finish;
    logic [3:0]  digit_count;
    modport master(output key_row, keyboard_in, keyboard_finish, digit_count, input key_col);
    modport slave(input key_row, keyboard_in, keyboard_finish, digit_count, output key_col);
endinterface

// File: rtl/key_sync.sv
// key_sync: 2-flop synchronizer for the asynchronous column inputs.
module key_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d,
    output logic [4:0] q
);
    logic [4:0] m;
    // Resets to the idle (pulled-up) level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m <= '1;
            q <= '1;
        end else begin
            m <= d;
            q <= m;
        end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x5 matrix keypad scanner with debounced hex-digit entry register.
module keypad_entry import kbd_pkg::*; #(
    parameter int SCAN_CYCLES     = 23000,
    parameter int DEBOUNCE_CYCLES = 230000
) (
    input logic            clk,
    input logic            rst_n,
    keypad_entry_if.master kb
);
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    state_t state, state_nx;
    logic [4:0] col_s, pat, pat_nx, key, key_nx;
    logic [1:0] row, row_nx;
    logic [SW-1:0] scan_cnt, scan_nx;
    logic [DW-1:0] db_cnt, db_nx;
    logic [31:0] value, value_nx;
    logic [3:0] count, count_nx;
    logic fresh, fresh_nx, finish, finish_nx;
    key_sync u_sync (.clk(clk), .rst_n(rst_n), .d(kb.key_col), .q(col_s));
    always_comb begin
        state_nx  = state;
        row_nx    = row;
        scan_nx   = scan_cnt;
        db_nx     = db_cnt;
        pat_nx    = pat;
        key_nx    = key;
        value_nx  = value;
        count_nx  = count;
        fresh_nx  = fresh;
        finish_nx = 1'b0;
        case (state)
            SCAN: begin
                if (col_s != 5'h1F) begin
                    state_nx = DEBOUNCE;
                    pat_nx   = col_s;
                    key_nx   = key_code(row, lowest_low(col_s));
                    db_nx    = '0;
                    scan_nx  = '0;
                end else begin
                    scan_nx = scan_cnt == SW'(SCAN_CYCLES - 1) ? '0 : scan_cnt + 1'b1;
                    row_nx  = scan_cnt == SW'(SCAN_CYCLES - 1) ? row + 2'd1 : row;
                end
            end
            DEBOUNCE: begin
                state_nx = col_s != pat ? SCAN : (db_cnt == DW'(DEBOUNCE_CYCLES - 1) ? ACT : DEBOUNCE);
                db_nx    = state_nx == DEBOUNCE ? db_cnt + 1'b1 : '0;
            end
            ACT: begin
                state_nx  = WAIT_RELEASE;
                finish_nx = key == K_ENTER;
                fresh_nx  = key == K_ENTER ? 1'b1 : (key == K_NOP ? fresh : 1'b0);
                if (key <= K_DF && (fresh || count < 4'(MAX_DIGITS))) begin
                    value_nx = fresh ? {28'h0, key[3:0]} : {value[27:0], key[3:0]};
                    count_nx = fresh ? 4'd1 : count + 4'd1;
                end else if (key == K_BKSP && count != 4'd0) begin
                    value_nx = value >> 4;
                    count_nx = count - 4'd1;
                end else if (key == K_CLR) begin
                    value_nx = '0;
                    count_nx = '0;
                end
            end
            WAIT_RELEASE: begin
                state_nx = col_s == 5'h1F && db_cnt == DW'(DEBOUNCE_CYCLES - 1) ? SCAN : WAIT_RELEASE;
                db_nx    = col_s != 5'h1F || state_nx == SCAN ? '0 : db_cnt + 1'b1;
            end
            default: state_nx = SCAN;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= SCAN;
            row      <= '0;
            scan_cnt <= '0;
            db_cnt   <= '0;
            pat      <= '1;
            key      <= K_NOP;
            value    <= '0;
            count    <= '0;
            fresh    <= 1'b0;
            finish   <= 1'b0;
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            scan_cnt <= scan_nx;
            db_cnt   <= db_nx;
            pat      <= pat_nx;
            key      <= key_nx;
            value    <= value_nx;
            count    <= count_nx;
            fresh    <= fresh_nx;
            finish   <= finish_nx;
        end
    assign kb.key_row         = ~(4'b0001 << row);
    assign kb.keyboard_in     = value;
    assign kb.digit_count     = count;
    assign kb.keyboard_finish = finish;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model driving directed and random key presses against an entry model.
module tb_keypad_entry;
    localparam int HOLD = 50;
    localparam int REL  = 24;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [19:0] held = '0;
    logic [4:0] col;
    int n_cmp = 0, n_bad = 0;
    int fin_cnt = 0, fin_wide = 0, exp_fin = 0;
    logic fin_prev = 1'b0;
    logic [31:0] fin_val = '0, exp_fin_val = '0;
    logic [31:0] m_val = '0;
    int m_cnt = 0;
    bit m_fresh = 0;
    keypad_entry_if kif();
    keypad_entry #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .kb(kif));
    always #5 clk = ~clk;
    // Closed switch shorts its column to the row only while that row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                if (held[r*5+c] && !kif.key_row[r]) col[c] = 1'b0;
    end
    assign kif.key_col = col;
    always @(negedge clk) begin
        if (kif.keyboard_finish) begin
            fin_cnt++;
            fin_val = kif.keyboard_in;
            if (fin_prev) fin_wide++;
        end
        fin_prev = kif.keyboard_finish;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic apply(input int r, input int c);
        if (c < 4) begin
            if (m_fresh) begin
                m_val = 4 * r + c;
                m_cnt = 1;
                m_fresh = 0;
            end else if (m_cnt < 8) begin
                m_val = m_val * 16 + 4 * r + c;
                m_cnt++;
            end
        end else if (r == 0) begin
            exp_fin++;
            exp_fin_val = m_val;
            m_fresh = 1;
        end else if (r == 1) begin
            if (m_cnt > 0) begin
                m_val = m_val / 16;
                m_cnt--;
            end
            m_fresh = 0;
        end else if (r == 2) begin
            m_val = 0;
            m_cnt = 0;
            m_fresh = 0;
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".value"}, kif.keyboard_in, m_val);
        chk({tag, ".count"}, 32'(kif.digit_count), 32'(m_cnt));
        chk({tag, ".fin_n"}, 32'(fin_cnt), 32'(exp_fin));
        chk({tag, ".fin_v"}, fin_val, exp_fin_val);
    endtask
    task automatic press(input int r, input int c);
        held[r*5+c] = 1'b1;
        repeat (HOLD) @(negedge clk);
        held = '0;
        repeat (REL) @(negedge clk);
        apply(r, c);
    endtask
    task automatic digit(input int d);
        press(d / 4, d % 4);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst.row", 32'(kif.key_row), 32'h0000000E);
        chk("rst.value", kif.keyboard_in, 32'h0);
        chk("rst.fin", 32'(kif.keyboard_finish), 32'h0);
        chk("rst.count", 32'(kif.digit_count), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        foreach (held[i]) ;
        digit(1); digit(2); digit(10); digit(15);
        press(0, 4);
        check_all("enter_12af");
        press(1, 4); press(1, 4);
        check_all("bksp_x2");
        press(2, 4);
        press(1, 4);
        check_all("bksp_zero");
        press(0, 4);
        check_all("enter_zero");
        for (int d = 1; d <= 9; d++) digit(d);
        check_all("nine_digits");
        press(2, 4); digit(3); digit(4); press(0, 4); digit(7);
        check_all("fresh_7");
        for (int i = 0; i < 6; i++) begin
            held[1*5+1] = i % 2 == 0;
            repeat (5) @(negedge clk);
        end
        digit(5);
        check_all("bounce");
        held[3*5+0] = 1'b1;
        repeat (4) @(negedge clk);
        held = '0;
        repeat (HOLD) @(negedge clk);
        check_all("glitch");
        held[1*5+3] = 1'b1;
        press(1, 2);
        check_all("same_row");
        held[1*5+1] = 1'b1;
        repeat (HOLD) @(negedge clk);
        held[1*5+0] = 1'b1;
        held[2*5+0] = 1'b1;
        repeat (20) @(negedge clk);
        held = '0;
        repeat (REL) @(negedge clk);
        apply(1, 1);
        check_all("frozen_row");
        held[2*5+1] = 1'b1;
        repeat (HOLD) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst.row", 32'(kif.key_row), 32'h0000000E);
        chk("midrst.value", kif.keyboard_in, 32'h0);
        chk("midrst.count", 32'(kif.digit_count), 32'h0);
        chk("midrst.fin", 32'(kif.keyboard_finish), 32'h0);
        m_val = 0; m_cnt = 0; m_fresh = 0;
        rst_n = 1'b1;
        press(2, 1);
        check_all("after_rst");
        for (int i = 0; i < 40; i++) begin
            int r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 4);
            press(r, c);
            check_all($sformatf("rnd%0d", i));
        end
        chk("fin_width", 32'(fin_wide), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
